// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } rst_seq_state_t;

  localparam logic [7:0] RST_SEQ_CNT_SAT = 8'hFF;

  // Largest of three timing parameters; sizes the shared delay counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_signal.sv
// N-flop single-bit synchronizer for bringing a level signal into the clk domain.
module sync_signal #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one flop further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Chain flops clear to 0 so lock reads as absent straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: qualifies lock, then releases per-subsystem resets in order.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int LOCK_STABLE = 256,
  parameter int STAGE_DELAY = 1024,
  parameter int HOLD_CYCLES = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lock_in,
  input  logic                sw_rst_req,
  output logic [N_STAGES-1:0] rst_out,
  output logic                all_ready,
  output logic [2:0]          state_out,
  output logic [7:0]          lock_loss_cnt
);

  localparam int CNT_W = $clog2(max3(LOCK_STABLE, STAGE_DELAY, HOLD_CYCLES)) + 1;
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_STAGES - 1);

  logic                lock_s;
  rst_seq_state_t      state_q,         state_d;
  logic [CNT_W-1:0]    cnt_q,           cnt_d;
  logic [IDX_W-1:0]    idx_q,           idx_d;
  logic [N_STAGES-1:0] rst_out_q,       rst_out_d;
  logic                all_ready_q,     all_ready_d;
  logic [7:0]          lock_loss_cnt_q, lock_loss_cnt_d;

  sync_signal #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(clk),
    .rst(rst),
    .d  (lock_in),
    .q  (lock_s)
  );

  // Next-state logic: lock qualification, staged release, and collective re-reset.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    rst_out_d       = rst_out_q;
    all_ready_d     = all_ready_q;
    lock_loss_cnt_d = lock_loss_cnt_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        rst_out_d   = '1;
        all_ready_d = 1'b0;
        cnt_d       = '0;
        idx_d       = '0;
        if (lock_s) begin
          state_d = ST_STABLE;
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (sw_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (!lock_s) begin
          state_d     = ST_WAIT_LOCK;
          rst_out_d   = '1;
          all_ready_d = 1'b0;
          cnt_d       = '0;
          idx_d       = '0;
          if (lock_loss_cnt_q != RST_SEQ_CNT_SAT) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
          end
        end else if (sw_rst_req) begin
          state_d     = ST_HOLD;
          rst_out_d   = '1;
          all_ready_d = 1'b0;
          cnt_d       = '0;
          idx_d       = '0;
        end else if (state_q == ST_RELEASE) begin
          if (cnt_q == STAGE_LAST) begin
            rst_out_d[idx_q] = 1'b0;
            cnt_d            = '0;
            if (idx_q == IDX_LAST) begin
              state_d     = ST_RUN;
              all_ready_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        rst_out_d   = '1;
        all_ready_d = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = lock_s ? ST_STABLE : ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d     = ST_WAIT_LOCK;
        rst_out_d   = '1;
        all_ready_d = 1'b0;
        cnt_d       = '0;
        idx_d       = '0;
      end
    endcase
  end

  // All sequencer state and registered outputs; rst forces every reset back on at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_WAIT_LOCK;
      cnt_q           <= '0;
      idx_q           <= '0;
      rst_out_q       <= '1;
      all_ready_q     <= 1'b0;
      lock_loss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      rst_out_q       <= rst_out_d;
      all_ready_q     <= all_ready_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign rst_out       = rst_out_q;
  assign all_ready     = all_ready_q;
  assign state_out     = state_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: timeline vectors, corner sequences, random run vs model.
module tb_rst_sequencer;

  localparam int N  = 3;
  localparam int LS = 8;
  localparam int SD = 4;
  localparam int HC = 5;
  localparam int SS = 2;

  localparam int M_WAIT    = 0;
  localparam int M_STABLE  = 1;
  localparam int M_RELEASE = 2;
  localparam int M_RUN     = 3;
  localparam int M_HOLD    = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         lock_in = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic [N-1:0] rst_out;
  logic         all_ready;
  logic [2:0]   state_out;
  logic [7:0]   lock_loss_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    int         cyc;
    logic       lock;
    logic       sw;
    logic [2:0] exp_rst;
    logic       exp_ready;
    logic [2:0] exp_state;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: phase plus cycles elapsed in that phase.
  int   m_state = M_WAIT;
  int   m_el    = 0;
  int   m_loss  = 0;
  int   m_cyc   = 0;
  logic m_ls    = 1'b0;
  logic lk_q[$] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  rst_sequencer #(
    .N_STAGES   (N),
    .LOCK_STABLE(LS),
    .STAGE_DELAY(SD),
    .HOLD_CYCLES(HC),
    .SYNC_STAGES(SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lock_in      (lock_in),
    .sw_rst_req   (sw_rst_req),
    .rst_out      (rst_out),
    .all_ready    (all_ready),
    .state_out    (state_out),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // Compare all four observable outputs against one expectation.
  task automatic checkOutput(input string name, input logic [N-1:0] er, input logic ed,
                             input logic [2:0] es, input logic [7:0] ec);
    checks_total++;
    if (rst_out === er && all_ready === ed && state_out === es && lock_loss_cnt === ec) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got rst_out=%b all_ready=%b state=%0d cnt=%0d, want rst_out=%b all_ready=%b state=%0d cnt=%0d",
               name, rst_out, all_ready, state_out, lock_loss_cnt, er, ed, es, ec);
    end
  endtask

  // Drive inputs for one cycle and return at the following falling edge.
  task automatic applyStimulus(input logic l, input logic s);
    lock_in    = l;
    sw_rst_req = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold lock at level l until the DUT reports state st, within a cycle budget.
  task automatic waitState(input string name, input logic l, input logic [2:0] st, input int budget);
    int n;
    n = 0;
    while (state_out !== st && n < budget) begin
      applyStimulus(l, 1'b0);
      n++;
    end
    if (state_out !== st) begin
      checks_total++;
      $display("[TB] FAIL %s timeout: state=%0d want %0d", name, state_out, st);
    end
  endtask

  function automatic void add_vec(input int c, input logic l, input logic s, input logic [2:0] r,
                                  input logic rd, input logic [2:0] st, input logic [7:0] cn);
    vec_t v;
    v.cyc = c; v.lock = l; v.sw = s; v.exp_rst = r;
    v.exp_ready = rd; v.exp_state = st; v.exp_cnt = cn;
    vecs.push_back(v);
  endfunction

  function automatic logic [N-1:0] model_rst();
    logic [N-1:0] r;
    r = '1;
    if (m_state == M_RUN) r = '0;
    else if (m_state == M_RELEASE) begin
      for (int k = 0; k < N; k++) r[k] = (k >= m_el / SD);
    end
    return r;
  endfunction

  // Model steps on the same edges as the DUT; lock path is a FIFO of sampled lock_in.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = M_WAIT;
      m_el    = 0;
      m_loss  = 0;
      lk_q.delete();
      for (int i = 0; i < SS; i++) lk_q.push_back(1'b0);
    end else begin
      m_cyc++;
      m_ls = lk_q[$];
      case (m_state)
        M_WAIT: if (m_ls) begin m_state = M_STABLE; m_el = 0; end
        M_STABLE: begin
          if (!m_ls) m_state = M_WAIT;
          else if (sw_rst_req) m_el = 0;
          else if (m_el == LS - 1) begin m_state = M_RELEASE; m_el = 0; end
          else m_el++;
        end
        M_RELEASE, M_RUN: begin
          if (!m_ls) begin
            m_state = M_WAIT;
            if (m_loss < 255) m_loss++;
          end else if (sw_rst_req) begin
            m_state = M_HOLD;
            m_el = 0;
          end else if (m_state == M_RELEASE) begin
            m_el++;
            if (m_el == N * SD) m_state = M_RUN;
          end
        end
        default: begin
          if (m_el == HC - 1) begin
            m_state = m_ls ? M_STABLE : M_WAIT;
            m_el = 0;
          end else m_el++;
        end
      endcase
      lk_q.push_front(lock_in);
      void'(lk_q.pop_back());
    end
  end

  // Continuous comparison of the DUT against the model between edges.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput($sformatf("model c%0d", m_cyc), model_rst(), (m_state == M_RUN),
                  3'(m_state), 8'(m_loss));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic lvl;
    logic s;
    int   vi;

    // Timeline: bring-up, RUN lock loss, re-lock, sw reset, simultaneous event, STABLE glitch.
    add_vec(  0, 1, 0, 3'b111, 0, 0, 0);
    add_vec(  2, 1, 0, 3'b111, 0, 0, 0);
    add_vec(  3, 1, 0, 3'b111, 0, 1, 0);
    add_vec( 10, 1, 0, 3'b111, 0, 1, 0);
    add_vec( 11, 1, 0, 3'b111, 0, 2, 0);
    add_vec( 14, 1, 0, 3'b111, 0, 2, 0);
    add_vec( 15, 1, 0, 3'b110, 0, 2, 0);
    add_vec( 19, 1, 0, 3'b100, 0, 2, 0);
    add_vec( 22, 1, 0, 3'b100, 0, 2, 0);
    add_vec( 23, 1, 0, 3'b000, 1, 3, 0);
    add_vec( 30, 0, 0, 3'b000, 1, 3, 0);
    add_vec( 32, 0, 0, 3'b000, 1, 3, 0);
    add_vec( 33, 0, 0, 3'b111, 0, 0, 1);
    add_vec( 34, 1, 0, 3'b111, 0, 0, 1);
    add_vec( 37, 1, 0, 3'b111, 0, 1, 1);
    add_vec( 44, 1, 0, 3'b111, 0, 1, 1);
    add_vec( 45, 1, 0, 3'b111, 0, 2, 1);
    add_vec( 49, 1, 0, 3'b110, 0, 2, 1);
    add_vec( 57, 1, 0, 3'b000, 1, 3, 1);
    add_vec( 60, 1, 1, 3'b000, 1, 3, 1);
    add_vec( 61, 1, 0, 3'b111, 0, 4, 1);
    add_vec( 65, 1, 0, 3'b111, 0, 4, 1);
    add_vec( 66, 1, 0, 3'b111, 0, 1, 1);
    add_vec( 74, 1, 0, 3'b111, 0, 2, 1);
    add_vec( 86, 1, 0, 3'b000, 1, 3, 1);
    add_vec( 90, 0, 0, 3'b000, 1, 3, 1);
    add_vec( 92, 0, 1, 3'b000, 1, 3, 1);
    add_vec( 93, 0, 0, 3'b111, 0, 0, 2);
    add_vec( 96, 1, 0, 3'b111, 0, 0, 2);
    add_vec( 99, 1, 0, 3'b111, 0, 1, 2);
    add_vec(102, 0, 0, 3'b111, 0, 1, 2);
    add_vec(103, 1, 0, 3'b111, 0, 1, 2);
    add_vec(104, 1, 0, 3'b111, 0, 1, 2);
    add_vec(105, 1, 0, 3'b111, 0, 0, 2);
    add_vec(106, 1, 0, 3'b111, 0, 1, 2);
    add_vec(113, 1, 0, 3'b111, 0, 1, 2);
    add_vec(114, 1, 0, 3'b111, 0, 2, 2);
    add_vec(125, 1, 0, 3'b100, 0, 2, 2);
    add_vec(126, 1, 0, 3'b000, 1, 3, 2);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    lvl = 1'b0;
    vi  = 0;
    for (int c = 0; c <= 126; c++) begin
      s = 1'b0;
      if (vi < vecs.size() && vecs[vi].cyc == c) begin
        checkOutput($sformatf("vec c%0d", c), vecs[vi].exp_rst, vecs[vi].exp_ready,
                    vecs[vi].exp_state, vecs[vi].exp_cnt);
        lvl = vecs[vi].lock;
        s   = vecs[vi].sw;
        vi++;
      end
      applyStimulus(lvl, s);
    end

    // Async reset in the middle of RELEASE, observed between clock edges.
    applyStimulus(1'b1, 1'b1);
    waitState("enter release", 1'b1, 3'd2, 40);
    repeat (5) applyStimulus(1'b1, 1'b0);
    checkOutput("pre-reset release", 3'b110, 1'b0, 3'd2, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset", 3'b111, 1'b0, 3'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Repeated lock losses in RELEASE until the counter saturates.
    for (int i = 0; i < 260; i++) begin
      waitState("sat release", 1'b1, 3'd2, 40);
      waitState("sat loss", 1'b0, 3'd0, 10);
      if (i == 0) checkOutput("first loss", 3'b111, 1'b0, 3'd0, 8'd1);
      if (i == 254) checkOutput("loss 255", 3'b111, 1'b0, 3'd0, 8'd255);
    end
    checkOutput("saturated", 3'b111, 1'b0, 3'd0, 8'd255);

    // Random lock drops and software requests, checked by the model every cycle.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
